// File: rtl/bra_upd_queue.sv
// bra_upd_queue: in-order branch update queue for the branch predictor.
// Fetch pushes one prediction record per branch. Execute resolves records
// out of order by tag. The head retires in order and emits a one-cycle
// training pulse. A mispredicting retire also emits a GHR repair and a
// fetch flush/redirect, clears the queue and spends one cycle in RECOVER.
// Optional build macro: BRA_UPD_TARGET_CHK_EN. When it is defined, a taken
// branch whose resolved target differs from the predicted target also
// counts as a mispredict.
module bra_upd_queue #(
    parameter int GHR_W  = 14,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    // Push handshake: a record transfers on a rising edge where pre_valid
    // and pre_ready are both 1. pre_ready depends only on internal state and
    // never on pre_valid. pre_tag names the slot the record will occupy.
    input  logic              pre_valid,
    output logic              pre_ready,
    input  logic [ADDR_W-1:0] pre_pc,
    input  logic              pre_torn,
    input  logic [ADDR_W-1:0] pre_tar,
    input  logic [GHR_W-1:0]  pre_ghr,
    output logic [TAG_W-1:0]  pre_tag,
    input  logic              res_valid,
    input  logic [TAG_W-1:0]  res_tag,
    input  logic              res_torn,
    input  logic [ADDR_W-1:0] res_tar,
    output logic              up_en,
    output logic              up_torn,
    output logic [ADDR_W-1:0] up_addr,
    output logic [ADDR_W-1:0] up_tar,
    output logic              ghr_reen,
    output logic [GHR_W-1:0]  ghr_re,
    output logic              flush,
    output logic [ADDR_W-1:0] redir_addr,
    output logic [TAG_W:0]    count
);

    typedef enum logic {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_e;

    state_e state_q, state_d;

    logic [DEPTH-1:0]  valid_q, resolved_q;
    logic [DEPTH-1:0]  ptorn_q, atorn_q;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] atar_q [DEPTH];
    // Only the low GHR_W-1 bits survive the repair shift, so only they are kept.
    logic [GHR_W-2:0]  ghr_q  [DEPTH];
`ifdef BRA_UPD_TARGET_CHK_EN
    logic [ADDR_W-1:0] ptar_q [DEPTH];
    logic              unused_bits;
    assign unused_bits = pre_ghr[GHR_W-1];
`else
    logic [ADDR_W:0]   unused_bits;
    assign unused_bits = {pre_ghr[GHR_W-1], pre_tar};
`endif

    logic [TAG_W-1:0]  head_q, tail_q;
    logic [TAG_W:0]    count_q;

    logic              up_en_q, up_torn_q, ghr_reen_q, flush_q;
    logic [ADDR_W-1:0] up_addr_q, up_tar_q, redir_q;
    logic [GHR_W-1:0]  ghr_re_q;

    logic              push, res_ok, bypass, retire, mispredict, ret_torn;
    logic [ADDR_W-1:0] ret_tar;

    assign pre_ready  = (state_q == ST_RUN) && (count_q < (TAG_W+1)'(DEPTH));
    assign pre_tag    = tail_q;
    assign count      = count_q;
    assign up_en      = up_en_q;
    assign up_torn    = up_torn_q;
    assign up_addr    = up_addr_q;
    assign up_tar     = up_tar_q;
    assign ghr_reen   = ghr_reen_q;
    assign ghr_re     = ghr_re_q;
    assign flush      = flush_q;
    assign redir_addr = redir_q;

    // Event decode: push, resolve, head retire (with same-cycle resolve bypass) and mispredict.
    always_comb begin
        push     = pre_valid && pre_ready;
        res_ok   = res_valid && (state_q == ST_RUN) && valid_q[res_tag];
        bypass   = res_ok && (res_tag == head_q);
        retire   = (state_q == ST_RUN) && valid_q[head_q] && (resolved_q[head_q] || bypass);
        ret_torn = bypass ? res_torn : atorn_q[head_q];
        ret_tar  = bypass ? res_tar : atar_q[head_q];
        mispredict = retire && (ret_torn != ptorn_q[head_q]);
`ifdef BRA_UPD_TARGET_CHK_EN
        if (retire && ret_torn && (ret_tar != ptar_q[head_q])) begin
            mispredict = 1'b1;
        end
`endif
    end

    // Next state: a mispredict enters RECOVER, which always lasts one cycle.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RECOVER) begin
            state_d = ST_RUN;
        end else if (mispredict) begin
            state_d = ST_RECOVER;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, occupancy and per-entry flags; a mispredict clear wins over everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
        end else if (mispredict) begin
            valid_q    <= '0;
            resolved_q <= '0;
            head_q     <= head_q + 1'b1;
            tail_q     <= head_q + 1'b1;
            count_q    <= '0;
        end else begin
            if (res_ok) begin
                resolved_q[res_tag] <= 1'b1;
            end
            if (push) begin
                valid_q[tail_q]    <= 1'b1;
                resolved_q[tail_q] <= 1'b0;
                tail_q             <= tail_q + 1'b1;
            end
            if (retire) begin
                valid_q[head_q]    <= 1'b0;
                resolved_q[head_q] <= 1'b0;
                head_q             <= head_q + 1'b1;
            end
            if (push && !retire) begin
                count_q <= count_q + 1'b1;
            end else if (retire && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Record payload; validity is tracked by the flags, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]    <= pre_pc;
            ptorn_q[tail_q] <= pre_torn;
            ghr_q[tail_q]   <= pre_ghr[GHR_W-2:0];
`ifdef BRA_UPD_TARGET_CHK_EN
            ptar_q[tail_q]  <= pre_tar;
`endif
        end
        if (res_ok) begin
            atorn_q[res_tag] <= res_torn;
            atar_q[res_tag]  <= res_tar;
        end
    end

    // Registered retire/repair outputs: strobes pulse for one cycle, data holds between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_en_q    <= 1'b0;
            up_torn_q  <= 1'b0;
            up_addr_q  <= '0;
            up_tar_q   <= '0;
            ghr_reen_q <= 1'b0;
            ghr_re_q   <= '0;
            flush_q    <= 1'b0;
            redir_q    <= '0;
        end else begin
            up_en_q    <= retire;
            ghr_reen_q <= mispredict;
            flush_q    <= mispredict;
            if (retire) begin
                up_torn_q <= ret_torn;
                up_addr_q <= pc_q[head_q];
                up_tar_q  <= ret_tar;
            end
            if (mispredict) begin
                ghr_re_q <= {ghr_q[head_q], ret_torn};
                redir_q  <= ret_torn ? ret_tar : pc_q[head_q] + ADDR_W'(4);
            end
        end
    end

endmodule

// File: tb/tb_bra_upd_queue.sv
// Self-checking bench for bra_upd_queue: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// record-queue model of the branch update queue.
module tb_bra_upd_queue;

  localparam int GHR_W  = 14;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pre_valid = 1'b0;
  logic              pre_ready;
  logic [ADDR_W-1:0] pre_pc = '0;
  logic              pre_torn = 1'b0;
  logic [ADDR_W-1:0] pre_tar = '0;
  logic [GHR_W-1:0]  pre_ghr = '0;
  logic [TAG_W-1:0]  pre_tag;
  logic              res_valid = 1'b0;
  logic [TAG_W-1:0]  res_tag = '0;
  logic              res_torn = 1'b0;
  logic [ADDR_W-1:0] res_tar = '0;
  logic              up_en, up_torn, ghr_reen, flush;
  logic [ADDR_W-1:0] up_addr, up_tar, redir_addr;
  logic [GHR_W-1:0]  ghr_re;
  logic [TAG_W:0]    count;

  bra_upd_queue #(.GHR_W(GHR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .pre_valid(pre_valid), .pre_ready(pre_ready), .pre_pc(pre_pc), .pre_torn(pre_torn),
    .pre_tar(pre_tar), .pre_ghr(pre_ghr), .pre_tag(pre_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_torn(res_torn), .res_tar(res_tar),
    .up_en(up_en), .up_torn(up_torn), .up_addr(up_addr), .up_tar(up_tar),
    .ghr_reen(ghr_reen), .ghr_re(ghr_re), .flush(flush), .redir_addr(redir_addr),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ptar;
    logic [ADDR_W-1:0] atar;
    logic [GHR_W-1:0]  ghr;
    logic              ptorn;
    logic              atorn;
    logic              resolved;
    int                tag;
  } rec_t;

  rec_t mq[$];          // outstanding records, oldest first
  int   m_next_tag = 0;
  bit   m_recover  = 1'b0;
  rec_t r, n;
  bit   push_ok, mis;

  logic              exp_up_en = 0, exp_up_torn = 0, exp_reen = 0, exp_flush = 0;
  logic [ADDR_W-1:0] exp_up_addr = '0, exp_up_tar = '0, exp_redir = '0;
  logic [GHR_W-1:0]  exp_ghr_re = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_next_tag = 0;
      m_recover = 1'b0;
      exp_up_en = 0; exp_up_torn = 0; exp_reen = 0; exp_flush = 0;
      exp_up_addr = '0; exp_up_tar = '0; exp_redir = '0; exp_ghr_re = '0;
    end else begin
      exp_up_en = 0;
      exp_reen  = 0;
      exp_flush = 0;
      if (m_recover) begin
        m_recover = 1'b0;
      end else begin
        push_ok = pre_valid && (mq.size() < DEPTH);
        if (res_valid) begin
          foreach (mq[i]) begin
            if (mq[i].tag == int'(res_tag)) begin
              mq[i].resolved = 1'b1;
              mq[i].atorn = res_torn;
              mq[i].atar = res_tar;
            end
          end
        end
        mis = 1'b0;
        if (mq.size() > 0 && mq[0].resolved) begin
          r = mq.pop_front();
          exp_up_en   = 1;
          exp_up_torn = r.atorn;
          exp_up_addr = r.pc;
          exp_up_tar  = r.atar;
          mis = (r.atorn != r.ptorn);
`ifdef BRA_UPD_TARGET_CHK_EN
          if (r.atorn && (r.atar != r.ptar)) mis = 1'b1;
`endif
        end
        if (mis) begin
          exp_reen   = 1;
          exp_flush  = 1;
          exp_ghr_re = GHR_W'((r.ghr << 1) | GHR_W'(r.atorn));
          exp_redir  = r.atorn ? r.atar : r.pc + 32'd4;
          mq.delete();
          m_next_tag = (r.tag + 1) % DEPTH;
          m_recover  = 1'b1;
        end else if (push_ok) begin
          n.pc = pre_pc; n.ptar = pre_tar; n.ghr = pre_ghr; n.ptorn = pre_torn;
          n.atar = '0; n.atorn = 1'b0; n.resolved = 1'b0; n.tag = m_next_tag;
          mq.push_back(n);
          m_next_tag = (m_next_tag + 1) % DEPTH;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("up_en",      up_en,      exp_up_en);
      chk("up_torn",    up_torn,    exp_up_torn);
      chk("up_addr",    up_addr,    exp_up_addr);
      chk("up_tar",     up_tar,     exp_up_tar);
      chk("ghr_reen",   ghr_reen,   exp_reen);
      chk("ghr_re",     ghr_re,     exp_ghr_re);
      chk("flush",      flush,      exp_flush);
      chk("redir_addr", redir_addr, exp_redir);
      chk("count",      count,      64'(mq.size()));
      chk("pre_ready",  pre_ready,  64'(!m_recover && (mq.size() < DEPTH)));
      chk("pre_tag",    pre_tag,    64'(m_next_tag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit pv, input logic [ADDR_W-1:0] pc, input bit ptorn,
                       input logic [ADDR_W-1:0] ptar, input logic [GHR_W-1:0] ghr,
                       input bit rv, input logic [TAG_W-1:0] rtag, input bit rtorn,
                       input logic [ADDR_W-1:0] rtar);
    pre_valid = pv; pre_pc = pc; pre_torn = ptorn; pre_tar = ptar; pre_ghr = ghr;
    res_valid = rv; res_tag = rtag; res_torn = rtorn; res_tar = rtar;
    @(posedge clk);
    #1;
    pre_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc, input bit ptorn,
                      input logic [ADDR_W-1:0] ptar, input logic [GHR_W-1:0] ghr);
    drive(1'b1, pc, ptorn, ptar, ghr, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic resolve(input logic [TAG_W-1:0] tag, input bit torn, input logic [ADDR_W-1:0] tar);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1, tag, torn, tar);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic random_cycle();
    bit pv, rv, rt;
    logic [TAG_W-1:0] tg;
    logic [ADDR_W-1:0] rtar;
    int cand[$];
    int k;
    pv = ($urandom_range(0, 99) < 60);
    rv = 1'b0; tg = '0; rt = 1'b0; rtar = '0;
    foreach (mq[i]) if (!mq[i].resolved) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(0, 99) < 55) begin
      k  = cand[$urandom_range(0, cand.size() - 1)];
      rv = 1'b1;
      tg = TAG_W'(mq[k].tag);
      rt = ($urandom_range(0, 99) < 85) ? mq[k].ptorn : ~mq[k].ptorn;
      rtar = ($urandom_range(0, 99) < 85) ? mq[k].ptar : ($urandom() & 32'hFFFF_FFFC);
    end else if ($urandom_range(0, 99) < 8) begin
      rv = 1'b1;
      tg = TAG_W'($urandom_range(0, DEPTH - 1));
      rt = 1'($urandom_range(0, 1));
      rtar = $urandom() & 32'hFFFF_FFFC;
    end
    drive(pv, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
          GHR_W'($urandom()), rv, tg, rt, rtar);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst count", count, 0);
    chk("rst pre_ready", pre_ready, 1);
    chk("rst pre_tag", pre_tag, 0);
    chk("rst up_en", up_en, 0);
    chk("rst flush", flush, 0);

    // In-order retire of out-of-order resolves
    push(32'h100, 0, 32'h0, 14'h0);
    push(32'h104, 0, 32'h0, 14'h0);
    push(32'h108, 0, 32'h0, 14'h0);
    chk("t1 count", count, 3);
    resolve(3'd2, 0, 32'h0);
    chk("t1 no up after tag2", up_en, 0);
    resolve(3'd1, 0, 32'h0);
    chk("t1 no up after tag1", up_en, 0);
    resolve(3'd0, 0, 32'h0);
    chk("t1 up_en first", up_en, 1);
    chk("t1 up_addr first", up_addr, 32'h100);
    idle();
    chk("t1 up_addr second", up_addr, 32'h104);
    idle();
    chk("t1 up_addr third", up_addr, 32'h108);
    chk("t1 no flush", flush, 0);
    idle();
    chk("t1 up_en done", up_en, 0);

    // Full queue, ignored push, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(4 * i), 0, 32'h0, 14'h0);
    chk("t2 count full", count, 8);
    chk("t2 pre_ready full", pre_ready, 0);
    chk("t2 tail wrapped", pre_tag, 0);
    push(32'hDEAD0, 0, 32'h0, 14'h0);
    chk("t2 9th ignored", count, 8);
    resolve(3'd0, 0, 32'h0);
    chk("t2 retire up_en", up_en, 1);
    chk("t2 retire addr", up_addr, 32'h1000);
    chk("t2 count after retire", count, 7);
    chk("t2 pre_ready again", pre_ready, 1);
    for (int i = 1; i < DEPTH; i++) resolve(3'(i), 0, 32'h0);
    chk("t2 drained", count, 0);
    idle();

    // Direction mispredict with GHR repair
    push(32'h200, 0, 32'h204, 14'h0155);
    resolve(3'd0, 1, 32'h400);
    chk("t3 up_en", up_en, 1);
    chk("t3 ghr_reen", ghr_reen, 1);
    chk("t3 flush", flush, 1);
    chk("t3 ghr_re", ghr_re, 14'h02AB);
    chk("t3 redir", redir_addr, 32'h400);
    chk("t3 count", count, 0);
    chk("t3 pre_ready recover", pre_ready, 0);
    idle();
    chk("t3 pre_ready back", pre_ready, 1);
    chk("t3 flush pulse", flush, 0);

    // Resolve to an invalid entry
    resolve(3'd5, 1, 32'h0);
    chk("t4 count", count, 0);
    chk("t4 up_en", up_en, 0);
    chk("t4 flush", flush, 0);

    // Correct direction, wrong target
    push(32'h300, 1, 32'h480, 14'h0);
    resolve(pre_tag - 3'd1, 1, 32'h500);
    chk("t5 up_en", up_en, 1);
    chk("t5 up_tar", up_tar, 32'h500);
`ifdef BRA_UPD_TARGET_CHK_EN
    chk("t5 flush", flush, 1);
    chk("t5 redir", redir_addr, 32'h500);
`else
    chk("t5 flush", flush, 0);
`endif
    idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) random_cycle();
    for (int c = 0; c < 20; c++) idle();

    // Asynchronous reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h700 + 32'(4 * i), 0, 32'h0, 14'h0);
    resolve(3'd0, 1, 32'h900);
    chk("t6 pre-reset flush", flush, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6 async count", count, 0);
    chk("t6 async up_en", up_en, 0);
    chk("t6 async flush", flush, 0);
    chk("t6 async redir", redir_addr, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    chk("t6 tag after reset", pre_tag, 0);
    push(32'h800, 0, 32'h0, 14'h0);
    chk("t6 count after push", count, 1);
    repeat (3) idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
